// File: rtl/phase_spike_encoder_4n_pkg.sv
// rtl/phase_spike_encoder_4n_pkg.sv - shared widths, state encoding and phase-code types
// Also used by phase_neuron and coincidence_detector.
package phase_spike_encoder_4n_pkg;

  localparam int PHASE_W = 8;
  localparam int NUM_CH  = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    EMIT = ST_EMIT
  } pse_state_e;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef phase_t [NUM_CH-1:0] phase_set_t;

endpackage

// File: rtl/phase_spike_encoder_4n_phase_cmp_chan.sv
// rtl/phase_spike_encoder_4n_phase_cmp_chan.sv - one channel: phase match, mask gate, fired hold
// fired_o shows the spike in its own clock and is cleared at the start of each gamma cycle.
module phase_cmp_chan
  import phase_spike_encoder_4n_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  phase_t gphase_i,
  input  phase_t code_i,
  input  logic   mask_i,
  input  logic   emit_i,
  input  logic   cycle_start_i,
  output logic   spike_o,
  output logic   fired_o
);

  logic fired_q, fired_d;

  assign spike_o = emit_i && mask_i && (gphase_i == code_i);
  assign fired_o = spike_o || (fired_q && !cycle_start_i);
  assign fired_d = fired_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fired_q <= 1'b0;
    end else begin
      fired_q <= fired_d;
    end
  end

endmodule

// File: rtl/phase_spike_encoder_4n.sv
// rtl/phase_spike_encoder_4n.sv - four-channel gamma-phase spike encoder with one pending slot
// Optional PSE_REPEAT_EN: re-emit the active set every cycle until a new set promotes.
module phase_spike_encoder_4n
  import phase_spike_encoder_4n_pkg::*;
#(
  parameter logic [8:0] CYCLE_LEN = 9'd256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] in_phase_a,
  input  logic [PHASE_W-1:0] in_phase_b,
  input  logic [PHASE_W-1:0] in_phase_c,
  input  logic [PHASE_W-1:0] in_phase_d,
  input  logic [NUM_CH-1:0]  in_mask,
  output logic [PHASE_W-1:0] gphase,
  output logic               cycle_start,
  output logic               spike_a,
  output logic               spike_b,
  output logic               spike_c,
  output logic               spike_d,
  output logic [NUM_CH-1:0]  fired,
  output logic               busy,
  output logic               cycle_done
);

  localparam phase_t LAST = phase_t'(CYCLE_LEN - 9'd1);

  phase_t            gphase_q, gphase_d;
  pse_state_e        state_q, state_d, state_eff, end_state;
  logic              pend_valid_q, pend_valid_d;
  phase_set_t        pend_code_q, pend_code_d, act_code_q, act_code_d, code_eff;
  logic [NUM_CH-1:0] pend_mask_q, pend_mask_d, act_mask_q, act_mask_d, mask_eff;
  logic [NUM_CH-1:0] spike_vec;
  logic              promote, emit, at_last;

`ifdef PSE_REPEAT_EN
  assign end_state = EMIT;
`else
  assign end_state = IDLE;
`endif

  // Promotion is visible in the gphase==0 clock itself so a code of 0 can fire there.
  assign cycle_start = (gphase_q == '0);
  assign at_last     = (gphase_q == LAST);
  assign promote     = cycle_start && pend_valid_q;
  assign state_eff   = promote ? EMIT : state_q;
  assign code_eff    = promote ? pend_code_q : act_code_q;
  assign mask_eff    = promote ? pend_mask_q : act_mask_q;
  assign emit        = (state_eff == EMIT);

  assign in_ready   = !pend_valid_q;
  assign gphase     = gphase_q;
  assign busy       = emit;
  assign cycle_done = emit && at_last;
  assign {spike_d, spike_c, spike_b, spike_a} = spike_vec;

  always_comb begin
    gphase_d     = at_last ? '0 : gphase_q + phase_t'(1);
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_mask_d  = pend_mask_q;
    act_code_d   = act_code_q;
    act_mask_d   = act_mask_q;

    if (in_valid && in_ready) begin
      pend_valid_d = 1'b1;
      pend_code_d  = {in_phase_d, in_phase_c, in_phase_b, in_phase_a};
      pend_mask_d  = in_mask;
    end

    // A new set always beats the end-of-cycle decision for the old one.
    if (promote) begin
      act_code_d   = pend_code_q;
      act_mask_d   = pend_mask_q;
      pend_valid_d = 1'b0;
      state_d      = EMIT;
    end else if (cycle_done) begin
      state_d = end_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gphase_q     <= '0;
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      pend_mask_q  <= '0;
      act_code_q   <= '0;
      act_mask_q   <= '0;
    end else begin
      gphase_q     <= gphase_d;
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_mask_q  <= pend_mask_d;
      act_code_q   <= act_code_d;
      act_mask_q   <= act_mask_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    phase_cmp_chan u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .gphase_i      (gphase_q),
      .code_i        (code_eff[i]),
      .mask_i        (mask_eff[i]),
      .emit_i        (emit),
      .cycle_start_i (cycle_start),
      .spike_o       (spike_vec[i]),
      .fired_o       (fired[i])
    );
  end

endmodule
